spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-port arbiter that shares the single-port 16K×16 SPRAM (SB_SPRAM256KA, one-cycle read latency) between two requesters inside the clash-generated core, e.g. a CPU port and a display/DMA port. Each cycle it issues at most one access to the RAM. Arbitration is round-robin, with an optional bounded lock so a requester can perform atomic read-modify-write sequences. Read data is returned with a per-requester valid strobe.

## Interface
Parameters:
- ADDR_W, 14, RAM word address width
- DATA_W, 16, RAM data width
- LOCK_MAX, 4, maximum consecutive grants to one locked requester before forced rotation (1..15)

Ports:
- clk  in  1  single clock for the block
- reset  in  1  reset, asynchronous, active-high
- mN_req  in  1  access request, N = 0, 1
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_W  word address
- mN_wdata  in  DATA_W  write data
- mN_lock  in  1  keep grant for the next access if still requesting
- mN_gnt  out  1  access issued this cycle (combinational)
- mN_rvalid  out  1  read data valid (registered)
- mN_rdata  out  DATA_W  read data; meaningful only while mN_rvalid
- ram_addr  out  ADDR_W  to SPRAM ADDRESS
- ram_wdata  out  DATA_W  to SPRAM DATAIN
- ram_wen  out  1  to SPRAM WREN
- ram_rdata  in  DATA_W  from SPRAM DATAOUT

## Operation
- Requester contract: hold req, we, addr and wdata stable until the cycle in which gnt is high. The access completes at that cycle's rising edge.
- Winner selection, evaluated combinationally each cycle:
  - If the lock owner is requesting and lock_cnt < LOCK_MAX, the owner wins.
  - Otherwise, if exactly one requester is requesting, it wins.
  - If both request, the requester that is not `last` wins.
- State registers:
  - `last`: index of the previous winner; reset 1, so m0 wins the first tie.
  - `owner_valid`, `owner`: current lock owner.
  - `lock_cnt`: 4 bits, counts consecutive grants to the owner.
  - `rd_pend[1:0]`: read issued in the previous cycle, one bit per requester.
- On each grant:
  - `last` ← winner.
  - `rd_pend[winner]` ← ~we; the other bit ← 0.
  - If the winner's lock = 1:
    - If the winner is already the owner, `lock_cnt` increments, saturating at LOCK_MAX.
    - Otherwise `owner` ← winner and `lock_cnt` ← 1.
  - If the winner's lock = 0, `owner_valid` ← 0.
- Lock release: the lock clears whenever the owner drops req. When `lock_cnt` = LOCK_MAX, the other requester, if requesting, wins the next cycle, and the lock then clears.
- RAM outputs:
  - With a winner: ram_addr/ram_wdata = winner's addr/wdata, and ram_wen = winner's we.
  - With no winner: ram_addr = 0, ram_wdata = 0, ram_wen = 0. The idle read is harmless.
- Read return: mN_rvalid = rd_pend[N]. Both mN_rdata outputs carry ram_rdata directly; consumers qualify them with rvalid.

## Timing
- Reset values: gnt 0, rvalid 0, ram_wen 0, ram_addr 0, last = 1, owner_valid = 0, lock_cnt = 0.
- While reset is high, all gnt outputs and ram_wen are forced to 0.
- Grant has zero latency: gnt is asserted in the same cycle as req if that requester wins.
- Read latency: rvalid is asserted exactly one cycle after the granted read cycle, for one cycle.
- Back-to-back reads by one requester give rvalid on consecutive cycles.
- Write: no response. Data is in RAM after the grant edge; a read granted in the next cycle returns the new value.
- Simultaneous requests with no lock alternate m0, m1, m0, …, so each requester sees at most one cycle of waiting.
- Reset asserted mid-read: the pending rvalid is dropped immediately (asynchronous clear). No data is returned after reset deasserts.
- lock with we = 1 followed by a read still follows the one-cycle read latency rule.

## Test plan
- **Single read:** reset, write 0xBEEF to addr 0x0123 via m0, then read via m0 → m0_gnt in both request cycles; m0_rvalid high one cycle after the read grant with m0_rdata = 0xBEEF; m1_rvalid stays 0.
- **Contention:** m0 and m1 both hold read req continuously for 6 cycles → grants m0, m1, m0, m1, m0, m1; each rvalid follows its grant by one cycle.
- **Lock, LOCK_MAX = 4:** m1 requests with lock while m0 also requests → m1 granted for 4 cycles, m0 granted on the 5th, and the lock is cleared afterwards.
- **Read-modify-write:** m0 locked read of 0x0010 (holding 5), then write of 6, while m1 continuously reads 0x0010 → m1 never observes a grant between m0's read and write; m1 then reads 6.
- **Idle:** no requests for 10 cycles → ram_wen = 0, ram_addr = 0, all gnt and rvalid outputs 0.
- **Reset mid-read:** assert reset in the cycle after an m1 read grant → m1_rvalid goes 0 immediately; after release, the first tie goes to m0.

Source files
------------

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port SPRAM (one-cycle read latency) between
// two requesters. Round-robin on ties, with a bounded lock that lets one
// requester keep the RAM for atomic read-modify-write sequences. Grants are
// combinational; read valids are registered one cycle after the read grant.
module spram_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 16,
   parameter int LOCK_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_lock,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_lock,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

   // Arbitration state
   logic       last_r;          // index of the previous winner
   logic       owner_valid_r;   // a lock is currently held
   logic       owner_r;         // which requester holds the lock
   logic [3:0] lock_cnt_r;      // consecutive grants to the lock owner
   logic [1:0] rd_pend_r;       // read issued last cycle, per requester

   // Combinational helpers
   logic [1:0] req_s;
   logic [1:0] we_s;
   logic [1:0] lock_s;
   logic       owner_hold_s;
   logic       win_valid_s;
   logic       win_s;

   assign req_s  = {m1_req,  m0_req};
   assign we_s   = {m1_we,   m0_we};
   assign lock_s = {m1_lock, m0_lock};

   // Winner selection: unexpired lock owner first, then sole requester, then round-robin
   always_comb begin
      win_valid_s  = 1'b0;
      win_s        = 1'b0;
      owner_hold_s = owner_valid_r && req_s[owner_r] && (lock_cnt_r < LOCK_MAX_C);
      if (reset) begin
         win_valid_s = 1'b0;
         win_s       = 1'b0;
      end else if (owner_hold_s) begin
         win_valid_s = 1'b1;
         win_s       = owner_r;
      end else begin
         case (req_s)
            2'b01: begin
               win_valid_s = 1'b1;
               win_s       = 1'b0;
            end
            2'b10: begin
               win_valid_s = 1'b1;
               win_s       = 1'b1;
            end
            2'b11: begin
               win_valid_s = 1'b1;
               win_s       = ~last_r;
            end
            default: begin
               win_valid_s = 1'b0;
               win_s       = 1'b0;
            end
         endcase
      end
   end

   assign m0_gnt = win_valid_s & ~win_s;
   assign m1_gnt = win_valid_s &  win_s;

   // RAM port mux: winner's access, or an all-zero idle read when nobody wins
   always_comb begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = {DATA_W{1'b0}};
      ram_wen   = 1'b0;
      if (win_valid_s) begin
         if (win_s) begin
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            ram_wen   = we_s[1];
         end else begin
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
            ram_wen   = we_s[0];
         end
      end else begin
         ram_addr  = {ADDR_W{1'b0}};
         ram_wdata = {DATA_W{1'b0}};
         ram_wen   = 1'b0;
      end
   end

   // Arbitration state update: round-robin pointer, lock tracking, read pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_r        <= 1'b1;
         owner_valid_r <= 1'b0;
         owner_r       <= 1'b0;
         lock_cnt_r    <= 4'd0;
         rd_pend_r     <= 2'b00;
      end else if (win_valid_s) begin
         last_r    <= win_s;
         rd_pend_r <= win_s ? {~we_s[1], 1'b0} : {1'b0, ~we_s[0]};
         if (lock_s[win_s]) begin
            if (owner_valid_r && (owner_r == win_s)) begin
               // Saturate so the owner keeps winning only while nobody else waits
               if (lock_cnt_r < LOCK_MAX_C) begin
                  lock_cnt_r <= lock_cnt_r + 4'd1;
               end else begin
                  lock_cnt_r <= lock_cnt_r;
               end
            end else begin
               owner_valid_r <= 1'b1;
               owner_r       <= win_s;
               lock_cnt_r    <= 4'd1;
            end
         end else begin
            owner_valid_r <= 1'b0;
            lock_cnt_r    <= 4'd0;
         end
      end else begin
         rd_pend_r <= 2'b00;
         // No winner while a lock is held means the owner stopped requesting
         if (owner_valid_r && !req_s[owner_r]) begin
            owner_valid_r <= 1'b0;
            lock_cnt_r    <= 4'd0;
         end else begin
            owner_valid_r <= owner_valid_r;
            lock_cnt_r    <= lock_cnt_r;
         end
      end
   end

   assign m0_rvalid = rd_pend_r[0];
   assign m1_rvalid = rd_pend_r[1];
   assign m0_rdata  = ram_rdata;
   assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed bench for spram_arbiter with a behavioural SPRAM
// and a scoreboard of expected read returns.
module tb_spram_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [13:0] m0_addr;
   logic [15:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
   logic [13:0] m1_addr;
   logic [15:0] m1_wdata, m1_rdata;
   logic [13:0] ram_addr;
   logic [15:0] ram_wdata, ram_rdata;
   logic        ram_wen;

   typedef struct {
      logic        idx;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_mis = 0;

   logic [15:0] mem [0:16383];

   spram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SPRAM: registered read, write on WREN
   always @(posedge clk) begin
      if (ram_wen) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk1(input string tag, input logic obs, input logic expv);
      n_vec++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic set_m(input int k, input logic req, input logic we,
                        input logic [13:0] addr, input logic [15:0] wd, input logic lk);
      if (k == 0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_lock = lk;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_lock = lk;
      end
   endtask

   task automatic clear_all();
      set_m(0, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      set_m(1, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
   endtask

   // One cycle: check grants and RAM port, retire due read, queue new read
   task automatic step(input logic eg0, input logic eg1, input logic [15:0] ed, input string tag);
      exp_t e;
      #1;
      chk1({tag, " gnt0"}, m0_gnt, eg0);
      chk1({tag, " gnt1"}, m1_gnt, eg1);
      if (eg0) begin
         chk16({tag, " ram_addr"}, {2'b00, ram_addr}, {2'b00, m0_addr});
         chk1({tag, " ram_wen"}, ram_wen, m0_we);
         if (m0_we) chk16({tag, " ram_wdata"}, ram_wdata, m0_wdata);
      end else if (eg1) begin
         chk16({tag, " ram_addr"}, {2'b00, ram_addr}, {2'b00, m1_addr});
         chk1({tag, " ram_wen"}, ram_wen, m1_we);
         if (m1_we) chk16({tag, " ram_wdata"}, ram_wdata, m1_wdata);
      end else begin
         chk16({tag, " idle ram_addr"}, {2'b00, ram_addr}, 16'h0000);
         chk1({tag, " idle ram_wen"}, ram_wen, 1'b0);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk1({tag, " rvalid due"}, e.idx ? m1_rvalid : m0_rvalid, 1'b1);
         chk1({tag, " rvalid other"}, e.idx ? m0_rvalid : m1_rvalid, 1'b0);
         chk16({tag, " rdata"}, e.idx ? m1_rdata : m0_rdata, e.data);
      end else begin
         chk1({tag, " rvalid0"}, m0_rvalid, 1'b0);
         chk1({tag, " rvalid1"}, m1_rvalid, 1'b0);
      end
      if (eg0 && !m0_we) sb.push_back('{1'b0, ed});
      if (eg1 && !m1_we) sb.push_back('{1'b1, ed});
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      reset = 1'b1;
      clear_all();
      // Reset: a pending write request must not reach the RAM
      set_m(0, 1'b1, 1'b1, 14'h0123, 16'hBEEF, 1'b0);
      #1;
      chk1("rst gnt0", m0_gnt, 1'b0);
      chk1("rst gnt1", m1_gnt, 1'b0);
      chk1("rst ram_wen", ram_wen, 1'b0);
      chk16("rst ram_addr", {2'b00, ram_addr}, 16'h0000);
      chk1("rst rvalid0", m0_rvalid, 1'b0);
      chk1("rst rvalid1", m1_rvalid, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // Single write then read by m0
      step(1'b1, 1'b0, 16'h0000, "wr0123");
      set_m(0, 1'b1, 1'b0, 14'h0123, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'hBEEF, "rd0123");
      clear_all();
      step(1'b0, 1'b0, 16'h0000, "rd0123 ret");

      // Preload data; leaves last = m1 so the next tie goes to m0
      set_m(0, 1'b1, 1'b1, 14'h0100, 16'hA0A0, 1'b0);
      step(1'b1, 1'b0, 16'h0000, "wr0100");
      clear_all();
      set_m(1, 1'b1, 1'b1, 14'h0200, 16'hB1B1, 1'b0);
      step(1'b0, 1'b1, 16'h0000, "wr0200");

      // Contention: continuous reads alternate m0, m1, ...
      set_m(0, 1'b1, 1'b0, 14'h0100, 16'h0000, 1'b0);
      set_m(1, 1'b1, 1'b0, 14'h0200, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 16'hA0A0, "rr m0");
         step(1'b0, 1'b1, 16'hB1B1, "rr m1");
      end
      clear_all();
      step(1'b0, 1'b0, 16'h0000, "rr drain");

      // m0 writes 5 to 0x0010 (leaves last = m0, so m1 wins the next tie)
      set_m(0, 1'b1, 1'b1, 14'h0010, 16'h0005, 1'b0);
      step(1'b1, 1'b0, 16'h0000, "wr0010");

      // Lock: m1 holds 4 grants, then m0, then m1 re-acquires a fresh lock
      set_m(0, 1'b1, 1'b0, 14'h0100, 16'h0000, 1'b0);
      set_m(1, 1'b1, 1'b0, 14'h0200, 16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'hB1B1, "lock m1");
      step(1'b1, 1'b0, 16'hA0A0, "lock expire m0");
      step(1'b0, 1'b1, 16'hB1B1, "relock m1 a");
      step(1'b0, 1'b1, 16'hB1B1, "relock m1 b");
      clear_all();
      step(1'b0, 1'b0, 16'h0000, "lock drain");

      // Read-modify-write by m0 while m1 keeps reading the same word
      set_m(0, 1'b1, 1'b0, 14'h0010, 16'h0000, 1'b1);
      set_m(1, 1'b1, 1'b0, 14'h0010, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0005, "rmw read");
      set_m(0, 1'b1, 1'b1, 14'h0010, 16'h0006, 1'b0);
      step(1'b1, 1'b0, 16'h0000, "rmw write");
      set_m(0, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h0006, "rmw m1 read");

      // Idle with non-zero but unrequested inputs
      clear_all();
      set_m(0, 1'b0, 1'b1, 14'h3FFF, 16'hFFFF, 1'b1);
      set_m(1, 1'b0, 1'b1, 14'h1555, 16'h5555, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0000, "idle");

      // Reset mid-read: m1 read granted, reset in the following cycle
      clear_all();
      set_m(1, 1'b1, 1'b0, 14'h0200, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'hB1B1, "pre-rst m1 read");
      clear_all();
      set_m(0, 1'b1, 1'b0, 14'h0100, 16'h0000, 1'b0);
      #1;
      e = sb.pop_front();
      chk1("pre-rst rvalid1", m1_rvalid, 1'b1);
      chk16("pre-rst rdata1", m1_rdata, e.data);
      reset = 1'b1;
      #1;
      chk1("mid-rst rvalid1", m1_rvalid, 1'b0);
      chk1("mid-rst gnt0", m0_gnt, 1'b0);
      chk1("mid-rst ram_wen", ram_wen, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      set_m(0, 1'b1, 1'b0, 14'h0100, 16'h0000, 1'b0);
      set_m(1, 1'b1, 1'b0, 14'h0200, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'hA0A0, "post-rst tie m0");
      step(1'b0, 1'b1, 16'hB1B1, "post-rst tie m1");
      clear_all();
      step(1'b0, 1'b0, 16'h0000, "post-rst drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
